sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Parametrised synchronous FIFO, the next generation of the team's 16x8 FIFO. It stores all DEPTH entries; the previous design capped occupancy at DEPTH-1. It adds simultaneous read/write, programmable almost-full and almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags and a first-word-fall-through (FWFT) mode. It sits between a single-clock producer and consumer as a general-purpose elastic buffer.

## Interface
Parameters:
- WIDTH, 8: data width in bits, minimum 1.
- DEPTH, 16: number of entries. Must be a power of two, minimum 2. AW = $clog2(DEPTH).
- AF_LEVEL, DEPTH-2: almost_full is asserted when count >= AF_LEVEL. Legal range 1..DEPTH.
- AE_LEVEL, 2: almost_empty is asserted when count <= AE_LEVEL. Legal range 0..DEPTH-1.
- FWFT, 0: read mode. 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- clk, in, 1: the single clock. One clock; reset is asynchronous and active-low.
- rst_n, in, 1: asynchronous active-low reset. Asserts immediately; deasserts synchronously to clk.
- wr, in, 1: write request.
- din, in, WIDTH: write data.
- rd, in, 1: read request. In FWFT mode this is a pop.
- dout, out, WIDTH: read data.
- full, out, 1: count == DEPTH.
- empty, out, 1: count == 0.
- almost_full, out, 1: count >= AF_LEVEL.
- almost_empty, out, 1: count <= AE_LEVEL.
- count, out, AW+1: current occupancy, range 0..DEPTH.
- overflow, out, 1: sticky; set by a rejected write.
- underflow, out, 1: sticky; set by a rejected read.
- err_clr, in, 1: synchronous clear of overflow and underflow.

## Operation
Accept rules:
- Write accepted: wa = wr && (!full || ra).
- Read accepted: ra = rd && !empty.
- On wa, mem[wptr] <= din and wptr increments.
- On ra, rptr increments.
- Pointers are AW bits wide and wrap naturally from DEPTH-1 to 0. There is no special wrap compare.

Count update on each clk edge:
- wa only: +1.
- ra only: -1.
- Both: unchanged.
- Neither: unchanged.

Boundary conditions:
- Full with rd && wr: both are accepted, count stays DEPTH, no overflow.
- Empty with rd && wr: the write is accepted and the read is rejected. count becomes 1 and underflow is set.
- Rejected write (wr && full && !ra): memory and pointers are unchanged; overflow <= 1.
- Rejected read (rd && empty): pointers are unchanged; underflow <= 1. In standard mode dout holds its value.

Error flags:
- err_clr clears overflow and underflow on the next edge.
- If a new error event occurs in the same cycle as err_clr, the set wins.

Read modes:
- FWFT=0: dout is a register. On ra, dout <= mem[rptr]. Otherwise dout holds.
- FWFT=1: dout = mem[rptr] whenever !empty. dout is don't-care while empty. rd acknowledges (pops) the displayed word.

Status outputs:
- full, empty, almost_full and almost_empty are decoded from the count register only. They carry no combinational path from wr or rd.

Reset (asynchronous, while rst_n = 0):
- wptr = rptr = 0 and count = 0.
- empty = 1, full = 0, almost_full = 0.
- almost_empty = 1.
- overflow = underflow = 0.
- dout = 0 in FWFT=0 mode.
- Memory contents are not reset.
- Reset mid-operation discards all stored data. The first accepted write after release lands at address 0.

## Timing
- Write-to-count latency: 1 cycle. Flags update on the same edge as count.
- FWFT=0 read latency: data appears on dout 1 cycle after the edge where rd is sampled with !empty.
- FWFT=1 latency: after a write into an empty FIFO, empty deasserts and dout is valid 1 cycle after the write edge. A pop presents the next word 1 cycle later on the same edge.
- Throughput: one write and one read per cycle, sustained, at any occupancy from 1 to DEPTH-1.
- rst_n deassertion: the first operation is accepted on the first clk edge after rst_n is sampled high.

## Test plan
All scenarios use WIDTH=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2 unless stated.

1. Reset, then write 16 words (0x10..0x1F) -> count = 16, full = 1 after the 16th edge. almost_full rises at count 14. No overflow.
2. Continue with a 17th write while full and rd=0 -> overflow = 1, count stays 16. Then 16 reads return 0x10..0x1F in order. empty = 1 after the last read. almost_empty rises at count 2.
3. Fill to 16, then drive rd=wr=1 for 20 cycles with incrementing data -> count stays 16 throughout, no overflow. Read data stays in order across pointer wrap.
4. From empty, drive rd=wr=1 for one cycle -> count = 1, underflow = 1. Then err_clr=1 with rd=1 on a now-nonempty FIFO -> underflow = 0 on the next edge.
5. Write 8 words, then pull rst_n low between clock edges -> count = 0, empty = 1 and flags cleared immediately, with no clock edge. After release, a write of 0xA5 reads back as 0xA5.
6. FWFT=1: write 0x3C into an empty FIFO -> dout = 0x3C with empty = 0 one cycle later, before any rd. A pop then empties the FIFO.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO that holds all DEPTH entries.
// Supports simultaneous read/write, programmable thresholds, sticky error flags and a FWFT read mode.
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AF_C    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0]   AE_C    = (AW+1)'(AE_LEVEL);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1'b1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          wa_s, ra_s;

  // Accept decisions: a read frees a slot, so a full FIFO still takes a write alongside it.
  always_comb begin
    ra_s = rd && !empty_q;
    wa_s = wr && (!full_q || ra_s);
  end

  // Next-state for pointers, occupancy, status flags and sticky errors.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wa_s) begin
      wptr_d = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end
    if (ra_s) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end

    count_d = count_q;
    case ({wa_s, ra_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Flags are registered from the next count so they track the count register exactly.
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == {(AW+1){1'b0}});
    afull_d  = (count_d >= AF_C);
    aempty_d = (count_d <= AE_C);

    // A fresh error in the clearing cycle must survive, hence set-over-clear.
    ovf_d = (wr && !wa_s) || (ovf_q && !err_clr);
    unf_d = (rd && !ra_s) || (unf_q && !err_clr);
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= {AW{1'b0}};
      rptr_q   <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wa_s) begin
      mem_q[wptr_q] <= din;
    end
  end

  generate
    if (FWFT == 0) begin : g_std
      logic [WIDTH-1:0] dout_q;

      // Registered read port: loads only on an accepted read, otherwise holds.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q <= {WIDTH{1'b0}};
        end else if (ra_s) begin
          dout_q <= mem_q[rptr_q];
        end else begin
          dout_q <= dout_q;
        end
      end

      assign dout = dout_q;
    end else begin : g_fwft
      // Head word is always on display; rd acknowledges it.
      assign dout = mem_q[rptr_q];
    end
  endgenerate

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised and directed bench for sync_fifo_param: one standard and one FWFT instance share stimulus.
// Expected data is queued at issue time and checked by an independent monitor.
module tb_sync_fifo_param;

  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr = 1'b0, rd = 1'b0, err_clr = 1'b0;
  logic [7:0] din = 8'h00;

  logic [7:0] dout_s, dout_f;
  logic       full_s, empty_s, af_s, ae_s, ovf_s, unf_s;
  logic       full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
  logic [4:0] count_s, count_f;

  sync_fifo_param #(.WIDTH(8), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .wr(wr), .din(din), .rd(rd), .dout(dout_s),
    .full(full_s), .empty(empty_s), .almost_full(af_s), .almost_empty(ae_s),
    .count(count_s), .overflow(ovf_s), .underflow(unf_s), .err_clr(err_clr));

  sync_fifo_param #(.WIDTH(8), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .wr(wr), .din(din), .rd(rd), .dout(dout_f),
    .full(full_f), .empty(empty_f), .almost_full(af_f), .almost_empty(ae_f),
    .count(count_f), .overflow(ovf_f), .underflow(unf_f), .err_clr(err_clr));

  always #5 clk = ~clk;

  // Reference model: content queue plus sticky error bits, updated at issue time.
  logic [7:0] mq [$];
  logic [7:0] exp_q [$];
  logic       m_ovf = 1'b0, m_unf = 1'b0;
  logic       std_fire = 1'b0;
  int         n_pass = 0, n_tot = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act != exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic ec);
    logic ra, wa;
    @(negedge clk);
    wr = w; din = d; rd = r; err_clr = ec;
    ra = r && (mq.size() > 0);
    wa = w && ((mq.size() < DEPTH) || ra);
    std_fire = ra;
    if (ra) exp_q.push_back(mq.pop_front());
    if (wa) mq.push_back(d);
    m_ovf = (w && !wa) || (m_ovf && !ec);
    m_unf = (r && !ra) || (m_unf && !ec);
  endtask

  // Monitor: after each edge compare both instances against the model.
  initial begin
    logic f;
    forever begin
      @(posedge clk);
      f = std_fire;
      std_fire = 1'b0;
      #1;
      if (f) begin
        if (exp_q.size() == 0) chk("rd_scoreboard_empty", 1, 0);
        else chk("std_rd_data", dout_s, exp_q.pop_front());
      end
      chk("count", count_s, mq.size());
      chk("full", full_s, mq.size() == DEPTH);
      chk("empty", empty_s, mq.size() == 0);
      chk("almost_full", af_s, mq.size() >= AF);
      chk("almost_empty", ae_s, mq.size() <= AE);
      chk("overflow", ovf_s, m_ovf);
      chk("underflow", unf_s, m_unf);
      chk("fwft_count", count_f, mq.size());
      chk("fwft_empty", empty_f, mq.size() == 0);
      chk("fwft_flags", {af_f, ae_f, ovf_f, unf_f},
          {mq.size() >= AF, mq.size() <= AE, m_ovf, m_unf});
      if (mq.size() > 0) chk("fwft_dout", dout_f, mq[0]);
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dout", dout_s, 0);
    chk("reset_flags", {full_s, empty_s, af_s, ae_s, ovf_s, unf_s}, 6'b010100);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill to full, then one rejected write.
    for (int i = 0; i < 16; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("overflow_after_17th", ovf_s, 1);
    chk("full_after_17th", count_s, 16);

    // Drain in order, then a rejected read must leave dout untouched.
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    @(posedge clk); #2;
    chk("dout_hold_on_underflow", dout_s, 8'h1F);

    // Full with simultaneous read/write across pointer wrap.
    for (int i = 0; i < 16; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 8'h80 + 8'(i), 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Empty with rd and wr: write lands, read rejected; then clear while popping.
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("underflow_cleared", unf_s, 0);

    // FWFT: word visible one cycle after the write, before any rd.
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("fwft_first_word", dout_f, 8'h3C);
    chk("fwft_not_empty", empty_f, 0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    @(posedge clk); #2;
    chk("fwft_empty_after_pop", empty_f, 1);

    // Randomised traffic with occupancy bias changing per phase.
    for (int p = 0; p < 8; p++) begin
      int pw;
      pw = (p % 2 == 0) ? 75 : 30;
      for (int i = 0; i < 100; i++)
        step($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < 50,
             $urandom_range(0, 19) == 0);
    end

    // Asynchronous reset mid-operation.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    mq.delete(); exp_q.delete();
    m_ovf = 1'b0; m_unf = 1'b0; std_fire = 1'b0;
    #1;
    chk("async_rst_count", count_s, 0);
    chk("async_rst_flags", {full_s, empty_s, af_s, ae_s, ovf_s, unf_s}, 6'b010100);
    chk("async_rst_dout", dout_s, 0);
    chk("async_rst_fwft_count", count_f, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("post_reset_readback", dout_s, 8'hA5);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
